j1_stack_unit: RTL

- Parametrised hardware stack for the J1-family cores. Usable as either the data stack or the return stack.
- Replaces the fixed-depth circular stack with one configurable in width and depth.
- Adds a selectable overflow mode (wrap or saturate), occupancy tracking, sticky overflow/underflow flags and a high-water mark.
- Lets firmware detect stack abuse and size stacks from measured depth.

---
 rtl/j1_stack_pkg.sv | 21 ++
 rtl/j1_stack_if.sv | 31 +++
 rtl/j1_stack_regfile.sv | 24 ++
 rtl/j1_stack_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/j1_stack_pkg.sv
// Shared definitions for the J1 parametrised stack: delta encodings, move
// classification and the delta sign-extension helper.
package j1_stack_pkg;

  localparam logic [1:0] DELTA_NONE = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;
  localparam logic [1:0] DELTA_POP2 = 2'b10;

  typedef enum logic [1:0] {
    MV_OK  = 2'b00,
    MV_OVF = 2'b01,
    MV_UNF = 2'b10
  } move_e;

  // Callers size-cast the 32-bit result down to whatever width they need.
  function automatic logic signed [31:0] sext_delta(input logic [1:0] d);
    return {{30{d[1]}}, d};
  endfunction

endpackage

// File: rtl/j1_stack_if.sv
// Core-to-stack port bundle: move/write request from the core, stack top and
// occupancy/health status back from the stack.
interface j1_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic             we;
  logic [WIDTH-1:0] wd;
  logic [1:0]       delta;
  logic             clr_err;
  logic [WIDTH-1:0] rd;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic [DW-1:0]    hwm;

  modport master (
    output we, wd, delta, clr_err,
    input  rd, depth, empty, full, ovf, unf, hwm
  );

  modport slave (
    input  we, wd, delta, clr_err,
    output rd, depth, empty, full, ovf, unf, hwm
  );

endinterface

// File: rtl/j1_stack_regfile.sv
// Stack storage: DEPTH x WIDTH cells, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module j1_stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wd;
  end

  assign rd = mem[raddr];

endmodule

// File: rtl/j1_stack_unit.sv
// Parametrised J1 data/return stack: pointer, occupancy, sticky overflow and
// underflow flags and high-water mark around a register-file store.
module j1_stack_unit
  import j1_stack_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic       clk,
  input  logic       rst,
  j1_stack_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam int IW = AW + 2;
  localparam logic signed [IW-1:0] DEPTH_S = IW'(DEPTH);

  function automatic logic [DW-1:0] clamp_depth(input logic signed [IW-1:0] s);
    if (s[IW-1])     return '0;
    if (s > DEPTH_S) return DW'(DEPTH);
    return s[DW-1:0];
  endfunction

  logic [AW-1:0]        sp;
  logic [AW-1:0]        sp_mv;
  logic [DW-1:0]        depth_q;
  logic [DW-1:0]        depth_nx;
  logic [DW-1:0]        hwm_q;
  logic [DW-1:0]        hwm_nx;
  logic                 ovf_q;
  logic                 unf_q;
  logic signed [IW-1:0] dx;
  logic signed [IW-1:0] depth_sum;
  move_e                mv;
  logic                 commit;
  logic                 wr_en;

  always_comb begin
    dx        = IW'(sext_delta(bus.delta));
    depth_sum = $signed({1'b0, depth_q}) + dx;
    sp_mv     = sp + AW'(dx);
    mv        = MV_OK;
    if (depth_sum[IW-1])       mv = MV_UNF;
    else if (depth_sum > DEPTH_S) mv = MV_OVF;
    // Wrap mode still performs an illegal move; saturate mode freezes state.
    commit    = (mv == MV_OK) || (SATURATE == 0);
    depth_nx  = commit ? clamp_depth(depth_sum) : depth_q;
    hwm_nx    = (bus.clr_err || (depth_nx > hwm_q)) ? depth_nx : hwm_q;
    wr_en     = bus.we && commit && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      depth_q <= '0;
      hwm_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (commit) sp <= sp_mv;
      depth_q <= depth_nx;
      hwm_q   <= hwm_nx;
      ovf_q   <= (ovf_q && !bus.clr_err) || (mv == MV_OVF);
      unf_q   <= (unf_q && !bus.clr_err) || (mv == MV_UNF);
    end
  end

  j1_stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_en),
    .waddr (sp_mv),
    .wd    (bus.wd),
    .raddr (sp),
    .rd    (bus.rd)
  );

  assign bus.depth = depth_q;
  assign bus.empty = (depth_q == '0);
  assign bus.full  = (depth_q == DW'(DEPTH));
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.hwm   = hwm_q;

endmodule
